// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel FIFO: default sizing, the
// controller state encoding and small helpers for packed FIFO entries.
package vga_pkg;

  // Default number of buffered pixels (power of two, at least 4)
  localparam int VGA_DEPTH  = 16;
  // Default pixel width: {r, g, b}, 8 bits per channel
  localparam int VGA_DATA_W = 24;

  // FILL: hunting for / waiting on a frame-aligned head.
  // RUN : streaming pixels to vga_control.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } vga_state_e;

  // A FIFO entry is {sof, rgb}; the sof flag sits in the top bit.
  function automatic logic entry_sof(input logic [VGA_DATA_W:0] entry);
    return entry[VGA_DATA_W];
  endfunction

  function automatic logic [VGA_DATA_W-1:0] entry_rgb(input logic [VGA_DATA_W:0] entry);
    return entry[VGA_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and wrap-around pointers.
// Pointers carry one extra bit so full and empty can be told apart.
// The head entry is presented on dout whenever the FIFO is not empty.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 25
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      wr_ptr_d;
  logic [AW:0]      rd_ptr_q;
  logic [AW:0]      rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; a flush wins over any push or pop in the same cycle
  always_comb begin
    do_push  = push && !full && !flush;
    do_pop   = pop && !empty && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Pointer registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/vga_pixel_fifo.sv
// Pixel FIFO between a pixel producer and vga_control. It discards
// pixels until it sees the start of a frame, starts streaming on
// frame_start once the head is frame-aligned, and falls back to FILL
// (flushing its contents and raising a sticky underflow) whenever it
// runs dry or detects loss of frame alignment.
module vga_pixel_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH  = VGA_DEPTH,
  parameter int DATA_W = VGA_DATA_W
) (
  input  logic                     clk_40m,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_W-1:0]        s_data,
  input  logic                     s_sof,
  input  logic                     frame_start,
  input  logic                     pix_req,
  output logic [7:0]               vga_r,
  output logic [7:0]               vga_g,
  output logic [7:0]               vga_b,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int EW = DATA_W + 1;

  vga_state_e        state_q;
  vga_state_e        state_d;
  vga_state_e        eff_state;
  logic              sof_seen_q;
  logic              sof_seen_d;
  logic              first_q;
  logic              first_d;
  logic              eff_first;
  logic              underflow_q;
  logic              underflow_d;
  logic [DATA_W-1:0] rgb_q;
  logic [DATA_W-1:0] rgb_d;
  logic              resync;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic              fifo_full;
  logic              fifo_empty;
  logic [EW-1:0]     fifo_dout;
  logic              head_sof;
  logic [DATA_W-1:0] head_rgb;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk_40m),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   ({s_sof, s_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign head_sof  = fifo_dout[DATA_W];
  assign head_rgb  = fifo_dout[DATA_W-1:0];
  assign s_ready   = !fifo_full;
  assign underflow = underflow_q;
  assign vga_r     = rgb_q[DATA_W-1 -: 8];
  assign vga_g     = rgb_q[DATA_W-9 -: 8];
  assign vga_b     = rgb_q[7:0];

  // Next-state logic: frame_start is resolved first, then pix_req is
  // served in the resulting state; any alignment loss triggers a resync
  always_comb begin
    state_d     = state_q;
    sof_seen_d  = sof_seen_q;
    first_d     = first_q;
    underflow_d = underflow_q;
    rgb_d       = rgb_q;
    fifo_pop    = 1'b0;
    fifo_flush  = 1'b0;
    fifo_push   = s_valid && s_ready && (sof_seen_q || s_sof);
    eff_state   = state_q;
    eff_first   = first_q;
    resync      = 1'b0;

    if (frame_start) begin
      if (!fifo_empty && head_sof) begin
        eff_state = ST_RUN;
        eff_first = 1'b1;
      end else if (state_q == ST_RUN) begin
        resync = 1'b1;
      end
    end

    if (pix_req) begin
      rgb_d = '0;
      if (!resync && (eff_state == ST_RUN)) begin
        if (fifo_empty) begin
          resync = 1'b1;
        end else if (head_sof && !eff_first) begin
          resync = 1'b1;
        end else begin
          fifo_pop  = 1'b1;
          rgb_d     = head_rgb;
          eff_first = 1'b0;
        end
      end
    end

    if (resync) begin
      state_d     = ST_FILL;
      first_d     = 1'b0;
      sof_seen_d  = 1'b0;
      underflow_d = 1'b1;
      fifo_flush  = 1'b1;
      fifo_pop    = 1'b0;
      fifo_push   = 1'b0;
    end else begin
      state_d = eff_state;
      first_d = eff_first;
      if (s_valid && s_ready && s_sof) begin
        sof_seen_d = 1'b1;
      end
    end
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge clk_40m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      sof_seen_q  <= 1'b0;
      first_q     <= 1'b0;
      underflow_q <= 1'b0;
      rgb_q       <= '0;
    end else begin
      state_q     <= state_d;
      sof_seen_q  <= sof_seen_d;
      first_q     <= first_d;
      underflow_q <= underflow_d;
      rgb_q       <= rgb_d;
    end
  end

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Self-checking bench for vga_pixel_fifo: directed scenarios followed by
// random traffic, checked by a queue-based reference model and a
// scoreboard monitor.
module tb_vga_pixel_fifo;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 24;

  logic              clk_40m;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_sof;
  logic              frame_start;
  logic              pix_req;
  logic [7:0]        vga_r;
  logic [7:0]        vga_g;
  logic [7:0]        vga_b;
  logic              underflow;
  logic [4:0]        level;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: buffered pixels as {sof, rgb}
  logic [DATA_W:0]   m_q [$];
  logic [DATA_W-1:0] exp_q [$];
  bit                m_run;
  bit                m_sof_seen;
  bit                m_first;
  bit                m_underflow;
  bit                req_pending;

  vga_pixel_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clk_40m     (clk_40m),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_sof       (s_sof),
    .frame_start (frame_start),
    .pix_req     (pix_req),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .underflow   (underflow),
    .level       (level)
  );

  // 40 MHz pixel clock
  initial clk_40m = 1'b0;
  always #12.5 clk_40m = ~clk_40m;

  // Hard time limit so the run always ends
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: applies the frame rules to a pixel queue per clock
  task automatic model_step();
    bit              ready;
    bit              acc;
    bit              have;
    bit              run;
    bit              first;
    bit              bad;
    bit              pop;
    logic [DATA_W:0] head;
    logic [DATA_W-1:0] out;
    ready = (m_q.size() < DEPTH);
    acc   = s_valid && ready;
    have  = (m_q.size() > 0);
    head  = have ? m_q[0] : '0;
    run   = m_run;
    first = m_first;
    bad   = 1'b0;
    pop   = 1'b0;
    out   = '0;
    if (frame_start) begin
      if (have && head[DATA_W]) begin
        run   = 1'b1;
        first = 1'b1;
      end else if (m_run) begin
        bad = 1'b1;
      end
    end
    if (pix_req && !bad && run) begin
      if (!have) bad = 1'b1;
      else if (head[DATA_W] && !first) bad = 1'b1;
      else begin
        pop   = 1'b1;
        out   = head[DATA_W-1:0];
        first = 1'b0;
      end
    end
    if (pix_req) begin
      exp_q.push_back(out);
      req_pending = 1'b1;
    end
    if (bad) begin
      m_underflow = 1'b1;
      m_run       = 1'b0;
      m_first     = 1'b0;
      m_sof_seen  = 1'b0;
      m_q.delete();
    end else begin
      m_run   = run;
      m_first = first;
      if (pop) void'(m_q.pop_front());
      if (acc && (m_sof_seen || s_sof)) m_q.push_back({s_sof, s_data});
      if (acc && s_sof) m_sof_seen = 1'b1;
    end
  endtask

  // Model clocking, with asynchronous reset
  initial begin
    forever begin
      @(posedge clk_40m or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        exp_q.delete();
        m_run       = 1'b0;
        m_sof_seen  = 1'b0;
        m_first     = 1'b0;
        m_underflow = 1'b0;
        req_pending = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  // Scoreboard monitor, sampling on the falling edge
  initial begin
    forever begin
      @(negedge clk_40m);
      if (rst_n) begin
        check("level", 32'(level), 32'(m_q.size()));
        check("underflow", 32'(underflow), 32'(m_underflow));
        check("s_ready", 32'(s_ready), 32'(m_q.size() < DEPTH));
        if (req_pending) begin
          req_pending = 1'b0;
          if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
          end else begin
            check("pixel", 32'({vga_r, vga_g, vga_b}), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic push_pixel(input logic [DATA_W-1:0] d, input logic sof);
    bit rdy;
    bit done;
    done    = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    for (int i = 0; i < 100 && !done; i++) begin
      rdy = s_ready;
      @(negedge clk_40m);
      if (rdy) done = 1'b1;
    end
    s_valid = 1'b0;
    s_sof   = 1'b0;
    if (!done) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    @(negedge clk_40m);
    frame_start = 1'b0;
  endtask

  task automatic reqs(input int n);
    pix_req = 1'b1;
    repeat (n) @(negedge clk_40m);
    pix_req = 1'b0;
  endtask

  task automatic reset_dut();
    #3 rst_n = 1'b0;
    @(negedge clk_40m);
    rst_n = 1'b1;
    @(negedge clk_40m);
  endtask

  task automatic apply_frame(input logic [DATA_W-1:0] base, input int n);
    for (int i = 0; i < n; i++) push_pixel(base + DATA_W'(i), i == 0);
  endtask

  initial begin
    s_valid     = 1'b0;
    s_data      = '0;
    s_sof       = 1'b0;
    frame_start = 1'b0;
    pix_req     = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk_40m);
    check("reset_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_ready", 32'(s_ready), 32'd1);
    check("reset_underflow", 32'(underflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk_40m);

    // Basic frame: four pixels out in order
    apply_frame(24'hA00001, 4);
    pulse_fs();
    reqs(4);
    check("basic_underflow", 32'(underflow), 32'd0);
    check("basic_last", 32'({vga_r, vga_g, vga_b}), 32'hA00004);

    // Fill to full, then a held write that completes after one pop
    for (int i = 0; i < DEPTH; i++) push_pixel(24'hB00000 + 24'(i), 1'b0);
    check("full_level", 32'(level), 32'd16);
    check("full_ready", 32'(s_ready), 32'd0);
    fork
      push_pixel(24'hB000FF, 1'b0);
      begin
        repeat (3) @(negedge clk_40m);
        reqs(1);
      end
    join
    check("full_after_pop", 32'(level), 32'd16);
    reqs(DEPTH);
    check("drain_last", 32'({vga_r, vga_g, vga_b}), 32'hB000FF);

    // Run dry: fourth request underflows
    reset_dut();
    apply_frame(24'hC00010, 3);
    pulse_fs();
    reqs(4);
    check("dry_black", 32'({vga_r, vga_g, vga_b}), 32'd0);
    check("dry_underflow", 32'(underflow), 32'd1);
    @(negedge clk_40m);
    check("dry_level", 32'(level), 32'd0);

    // Pixels before the first sof are dropped
    reset_dut();
    push_pixel(24'h111111, 1'b0);
    push_pixel(24'h222222, 1'b1);
    check("fill_level", 32'(level), 32'd1);
    pulse_fs();
    reqs(1);
    check("fill_first", 32'({vga_r, vga_g, vga_b}), 32'h222222);

    // Misaligned frame_start, then resync to the next sof
    reset_dut();
    apply_frame(24'hD00020, 3);
    pulse_fs();
    reqs(1);
    pulse_fs();
    check("misalign_underflow", 32'(underflow), 32'd1);
    check("misalign_level", 32'(level), 32'd0);
    apply_frame(24'hD00040, 2);
    pulse_fs();
    reqs(2);
    check("resync_pixel", 32'({vga_r, vga_g, vga_b}), 32'hD00041);

    // Reset mid-line with ten pixels buffered
    reset_dut();
    apply_frame(24'hE00000, 12);
    pulse_fs();
    reqs(2);
    check("midline_level", 32'(level), 32'd10);
    #3 rst_n = 1'b0;
    #1;
    check("async_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
    check("async_level", 32'(level), 32'd0);
    @(negedge clk_40m);
    rst_n = 1'b1;
    @(negedge clk_40m);
    apply_frame(24'hF00000, 4);
    pulse_fs();
    reqs(4);
    check("after_reset_pixel", 32'({vga_r, vga_g, vga_b}), 32'hF00003);
    check("after_reset_underflow", 32'(underflow), 32'd0);

    // Random traffic with occasional resets
    for (int c = 0; c < 2000; c++) begin
      if (c % 250 == 249) begin
        s_valid     = 1'b0;
        pix_req     = 1'b0;
        frame_start = 1'b0;
        reset_dut();
      end else begin
        s_valid     = ($urandom_range(0, 99) < 60);
        s_data      = DATA_W'($urandom);
        s_sof       = ($urandom_range(0, 9) == 0);
        pix_req     = ($urandom_range(0, 99) < 45);
        frame_start = ($urandom_range(0, 99) < 4);
        @(negedge clk_40m);
      end
    end
    s_valid     = 1'b0;
    pix_req     = 1'b0;
    frame_start = 1'b0;
    repeat (2) @(negedge clk_40m);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fifo.md
VGA_PIXEL_FIFO -- requirements
Module: vga_pixel_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of 2, at least 4).
REQ-002 The block SHALL have parameter DATA_W, default 24, meaning RGB word width ({r,g,b}, 8 bits each).
REQ-003 The block SHALL have port clk_40m, input, 1 bit: the single pixel clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port s_valid, input, 1 bit: producer pixel valid.
REQ-006 The block SHALL have port s_ready, output, 1 bit: FIFO accepts the pixel.
REQ-007 The block SHALL have port s_data, input, DATA_W bits: producer pixel.
REQ-008 The block SHALL have port s_sof, input, 1 bit: the pixel is frame pixel (0,0).
REQ-009 The block SHALL have port frame_start, input, 1 bit: one-cycle pulse from vga_control, one cycle before the first active pixel of a frame.
REQ-010 The block SHALL have port pix_req, input, 1 bit: vga_control requests one pixel (active video).
REQ-011 The block SHALL have ports vga_r, vga_g and vga_b, output, 8 bits each: pixel to vga_control.
REQ-012 The block SHALL have port underflow, output, 1 bit: sticky error flag.
REQ-013 The block SHALL have port level, output, $clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-014 Each FIFO entry SHALL be DATA_W+1 bits wide ({sof, rgb}), with a registered memory and wrap-around read/write pointers that carry one extra bit for full/empty.
REQ-015 A write SHALL occur iff s_valid && s_ready.
REQ-016 s_ready SHALL be !full, from registered state only (no combinational path from pix_req).
REQ-017 A pop SHALL occur iff pix_req is high, state is RUN and the FIFO is not empty.
REQ-018 Read latency SHALL be 1: vga_r/g/b SHALL update the cycle after a pix_req and hold between requests.
REQ-019 Write and pop in the same cycle SHALL leave level unchanged, and level SHALL never exceed DEPTH.
REQ-020 When the FIFO is empty there SHALL be no write-to-read bypass: a pix_req in the same cycle as a write counts as an underflow.
REQ-021 The FSM SHALL have exactly two states, FILL and RUN.
REQ-022 In FILL, writes with s_sof=0 SHALL be accepted and discarded (s_ready=1) until the first s_sof=1 write, which is stored; later writes are stored normally.
REQ-023 In FILL, the outputs SHALL be 0 (black) on every pix_req.
REQ-024 The FSM SHALL go FILL->RUN on frame_start when the FIFO head is valid and has sof=1; that head SHALL be popped by the next pix_req.
REQ-025 The FSM SHALL go RUN->FILL on a pix_req with the FIFO empty: the output is black, underflow is set, and the pointers are flushed next cycle.
REQ-026 The FSM SHALL go RUN->FILL on a frame_start whose head is empty or has sof=0 (misalignment): underflow is set and the FIFO is flushed.
REQ-027 If a pix_req pops an entry with sof=1 in RUN other than the first pixel after frame_start, that SHALL count as misalignment and be handled as in REQ-026.
REQ-028 When frame_start and pix_req occur in the same cycle, frame_start SHALL be evaluated first.
REQ-029 underflow SHALL clear only on reset.

Reset
REQ-030 rst_n low SHALL asynchronously set: state=FILL, pointers=0, level=0, vga_r/g/b=0, underflow=0, s_ready=1 and sof-seen=0.
REQ-031 Reset asserted mid-frame SHALL discard all buffered pixels; after deassertion the block SHALL behave as if freshly powered up.

Structure
REQ-032 The FSM state encoding and the default values of DEPTH and DATA_W SHALL live in the shared package vga_pkg.
REQ-033 The storage array and pointers SHALL be one sub-module, sync_fifo (parameters DEPTH and WIDTH; ports push, pop, din, dout, full, empty, level, flush); the FSM and the sof logic SHALL be in vga_pixel_fifo.

Verification
REQ-034 Reset, then write 4 pixels with the first having s_sof=1, then frame_start, then 4 pix_req -> outputs equal those pixels in order, each one cycle after its pix_req, underflow=0.
REQ-035 Write 16 pixels without popping -> level=16, s_ready=0; the 17th s_valid is held until one pop, then accepted.
REQ-036 In RUN, 3 pixels buffered and 4 pix_req -> 4th output 0x000000, underflow=1, state FILL, level=0 two cycles later.
REQ-037 In FILL, write 0x111111 with s_sof=0, then 0x222222 with s_sof=1 -> level=1, and after frame_start the first pixel out is 0x222222.
REQ-038 frame_start while the head has sof=0 -> underflow=1, flush, FILL; then re-sync to the next sof and output correct pixels.
REQ-039 rst_n pulsed low mid-line with 10 pixels buffered -> all outputs 0 immediately (asynchronously), level=0, and the next frame is handled correctly.
